// File: rtl/hvac_sequencer.sv
// HVAC plant sequencer: turns thermostat heat/cool requests into interlocked
// heater, cooler and fan enables with min-on, fan purge and anti-short-cycle lockout.
module hvac_sequencer #(
  parameter int MIN_ON  = 4,
  parameter int PURGE   = 2,
  parameter int MIN_OFF = 3,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       heat_req,
  input  logic       cool_req,
  output logic       heater_en,
  output logic       cooler_en,
  output logic       fan_en,
  output logic [2:0] state,
  output logic       conflict,
  output logic [7:0] heat_starts,
  output logic [7:0] cool_starts
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEAT    = 3'd1,
    ST_COOL    = 3'd2,
    ST_PURGE   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] PURGE_LAST = CNT_W'(PURGE - 1);
  localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX  = '1;

  state_t           cur;
  logic [CNT_W-1:0] timer;
  logic             valid_heat;
  logic             valid_cool;

  assign valid_heat = enable & heat_req & ~cool_req;
  assign valid_cool = enable & cool_req & ~heat_req;
  assign state      = cur;

  // Enables are assigned from the state being entered so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= ST_IDLE;
      timer       <= '0;
      heater_en   <= 1'b0;
      cooler_en   <= 1'b0;
      fan_en      <= 1'b0;
      conflict    <= 1'b0;
      heat_starts <= 8'd0;
      cool_starts <= 8'd0;
    end else begin
      conflict <= heat_req & cool_req;
      case (cur)
        ST_IDLE: begin
          timer <= '0;
          if (valid_heat) begin
            cur       <= ST_HEAT;
            heater_en <= 1'b1;
            cooler_en <= 1'b0;
            fan_en    <= 1'b1;
            if (heat_starts != 8'hFF) heat_starts <= heat_starts + 8'd1;
          end else if (valid_cool) begin
            cur       <= ST_COOL;
            heater_en <= 1'b0;
            cooler_en <= 1'b1;
            fan_en    <= 1'b1;
            if (cool_starts != 8'hFF) cool_starts <= cool_starts + 8'd1;
          end else begin
            heater_en <= 1'b0;
            cooler_en <= 1'b0;
            fan_en    <= 1'b0;
          end
        end
        ST_HEAT: begin
          // Dropping enable overrides the minimum on-time.
          if (!enable || (timer >= ON_LAST && !valid_heat)) begin
            cur       <= ST_PURGE;
            timer     <= '0;
            heater_en <= 1'b0;
            cooler_en <= 1'b0;
            fan_en    <= 1'b1;
          end else begin
            if (timer != TIMER_MAX) timer <= timer + 1'b1;
            heater_en <= 1'b1;
            cooler_en <= 1'b0;
            fan_en    <= 1'b1;
          end
        end
        ST_COOL: begin
          if (!enable || (timer >= ON_LAST && !valid_cool)) begin
            cur       <= ST_PURGE;
            timer     <= '0;
            heater_en <= 1'b0;
            cooler_en <= 1'b0;
            fan_en    <= 1'b1;
          end else begin
            if (timer != TIMER_MAX) timer <= timer + 1'b1;
            heater_en <= 1'b0;
            cooler_en <= 1'b1;
            fan_en    <= 1'b1;
          end
        end
        ST_PURGE: begin
          heater_en <= 1'b0;
          cooler_en <= 1'b0;
          if (timer >= PURGE_LAST) begin
            cur    <= ST_LOCKOUT;
            timer  <= '0;
            fan_en <= 1'b0;
          end else begin
            timer  <= timer + 1'b1;
            fan_en <= 1'b1;
          end
        end
        ST_LOCKOUT: begin
          heater_en <= 1'b0;
          cooler_en <= 1'b0;
          fan_en    <= 1'b0;
          if (timer >= OFF_LAST) begin
            cur   <= ST_IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          cur       <= ST_IDLE;
          timer     <= '0;
          heater_en <= 1'b0;
          cooler_en <= 1'b0;
          fan_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed self-checking bench for hvac_sequencer at default parameters.
module tb_hvac_sequencer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       heat_req;
  logic       cool_req;
  logic       heater_en;
  logic       cooler_en;
  logic       fan_en;
  logic [2:0] state;
  logic       conflict;
  logic [7:0] heat_starts;
  logic [7:0] cool_starts;

  int errors = 0;
  int checks = 0;

  hvac_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .heat_req    (heat_req),
    .cool_req    (cool_req),
    .heater_en   (heater_en),
    .cooler_en   (cooler_en),
    .fan_en      (fan_en),
    .state       (state),
    .conflict    (conflict),
    .heat_starts (heat_starts),
    .cool_starts (cool_starts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    heat_req = 1'b0;
    cool_req = 1'b0;
    enable = 1'b1;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic run_out(input string tag);
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      if (state == 3'd0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s_return_idle state=%0d required=0 within 40 cycles", tag, state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    heat_req = 1'b0;
    cool_req = 1'b0;
    #2;
    checks++;
    if ({state, heater_en, cooler_en, fan_en, conflict} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs state=%0d h=%b c=%b f=%b cf=%b required all 0",
               state, heater_en, cooler_en, fan_en, conflict);
    end
    checks++;
    if ({heat_starts, cool_starts} !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_counters heat=%0d cool=%0d required 0 0", heat_starts, cool_starts);
    end
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_basic_heat();
    logic       exp_h [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    logic       exp_f [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [2:0] exp_s [10] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0};
    apply_reset();
    heat_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      heat_req = 1'b0;
      checks++;
      if (heater_en !== exp_h[k] || fan_en !== exp_f[k] || state !== exp_s[k] || cooler_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_heat_edge%0d h=%b f=%b c=%b s=%0d required h=%b f=%b c=0 s=%0d",
                 k + 1, heater_en, fan_en, cooler_en, state, exp_h[k], exp_f[k], exp_s[k]);
      end
    end
    checks++;
    if (heat_starts !== 8'd1 || cool_starts !== 8'd0) begin
      errors++;
      $display("[TB] FAIL basic_heat_starts heat=%0d cool=%0d required 1 0", heat_starts, cool_starts);
    end
  endtask

  task automatic test_anti_short_cycle();
    apply_reset();
    heat_req = 1'b1;
    cycle();
    heat_req = 1'b0;
    repeat (3) cycle();
    checks++;
    if (heater_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL asc_on heater=%b required 1", heater_en);
    end
    cycle();
    heat_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) cycle();
      checks++;
      if (heater_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL asc_gap_cycle%0d heater=%b required 0", k + 1, heater_en);
      end
    end
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL asc_idle state=%0d required 0", state);
    end
    cycle();
    checks++;
    if (heater_en !== 1'b1 || heat_starts !== 8'd2) begin
      errors++;
      $display("[TB] FAIL asc_reassert heater=%b starts=%0d required 1 2", heater_en, heat_starts);
    end
    heat_req = 1'b0;
    run_out("asc");
  endtask

  task automatic test_conflict();
    bit done = 0;
    apply_reset();
    heat_req = 1'b1;
    cool_req = 1'b1;
    cycle();
    checks++;
    if (conflict !== 1'b1 || state !== 3'd0 || {heater_en, cooler_en, fan_en} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL conflict_flag cf=%b s=%0d h=%b c=%b f=%b required cf=1 s=0 enables 0",
               conflict, state, heater_en, cooler_en, fan_en);
    end
    cycle();
    checks++;
    if (state !== 3'd0 || heat_starts !== 8'd0 || cool_starts !== 8'd0) begin
      errors++;
      $display("[TB] FAIL conflict_hold s=%0d heat=%0d cool=%0d required 0 0 0", state, heat_starts, cool_starts);
    end
    heat_req = 1'b0;
    cycle();
    checks++;
    if (cooler_en !== 1'b1 || heater_en !== 1'b0 || state !== 3'd2 || conflict !== 1'b0 || cool_starts !== 8'd1) begin
      errors++;
      $display("[TB] FAIL changeover c=%b h=%b s=%0d cf=%b cs=%0d required c=1 h=0 s=2 cf=0 cs=1",
               cooler_en, heater_en, state, conflict, cool_starts);
    end
    cool_req = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      checks++;
      if (heater_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL changeover_no_heat cycle%0d heater=%b required 0", i, heater_en);
      end
      if (state == 3'd0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL changeover_return_idle state=%0d required 0", state);
    end
  endtask

  task automatic test_forced_shutdown();
    logic       exp_f [6] = '{1, 1, 0, 0, 0, 0};
    logic [2:0] exp_s [6] = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0};
    apply_reset();
    heat_req = 1'b1;
    cycle();
    cycle();
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if (heater_en !== 1'b0 || fan_en !== exp_f[k] || state !== exp_s[k]) begin
        errors++;
        $display("[TB] FAIL shutdown_step%0d h=%b f=%b s=%0d required h=0 f=%b s=%0d",
                 k + 1, heater_en, fan_en, state, exp_f[k], exp_s[k]);
      end
    end
    cycle();
    checks++;
    if (state !== 3'd0 || heater_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL shutdown_disabled_idle s=%0d h=%b required 0 0", state, heater_en);
    end
    enable = 1'b1;
    heat_req = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    cool_req = 1'b1;
    cycle();
    checks++;
    if (cooler_en !== 1'b1 || fan_en !== 1'b1 || cool_starts !== 8'd1) begin
      errors++;
      $display("[TB] FAIL areset_precool c=%b f=%b cs=%0d required 1 1 1", cooler_en, fan_en, cool_starts);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cooler_en, fan_en, heater_en} !== 3'b000 || state !== 3'd0 || cool_starts !== 8'd0) begin
      errors++;
      $display("[TB] FAIL areset_drop c=%b f=%b h=%b s=%0d cs=%0d required all 0",
               cooler_en, fan_en, heater_en, state, cool_starts);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
    checks++;
    if (cooler_en !== 1'b1 || state !== 3'd2 || cool_starts !== 8'd1) begin
      errors++;
      $display("[TB] FAIL areset_resume c=%b s=%0d cs=%0d required 1 2 1", cooler_en, state, cool_starts);
    end
    cool_req = 1'b0;
    run_out("areset");
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int n = 1; n <= 300; n++) begin
      heat_req = 1'b1;
      cycle();
      heat_req = 1'b0;
      run_out("sat");
      if (n == 1 || n == 254 || n == 255 || n == 300) begin
        checks++;
        if (heat_starts !== ((n > 255) ? 8'd255 : 8'(n))) begin
          errors++;
          $display("[TB] FAIL sat_count_n%0d heat_starts=%0d required %0d",
                   n, heat_starts, (n > 255) ? 255 : n);
        end
      end
    end
    checks++;
    if (cool_starts !== 8'd0) begin
      errors++;
      $display("[TB] FAIL sat_cool_starts cool=%0d required 0", cool_starts);
    end
  endtask

  initial begin
    test_reset();
    test_basic_heat();
    test_anti_short_cycle();
    test_conflict();
    test_forced_shutdown();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
